// File: rtl/config_stream_loader.sv
// config_stream_loader
//   Receives the device bitstream as WORD_W-bit words over a valid/ready
//   handshake and serialises them, LSB first, into the CB, SB, CLB and IO
//   configuration chains in that fixed order. Each chain section starts on
//   a word boundary; unused tail bits of a section's last word are dropped.
//
// Ports
//   clk         configuration clock
//   reset       asynchronous active-low reset
//   start       single-cycle pulse, begins a pass (ignored unless idle)
//   word_in     bitstream word
//   word_valid  word_in is valid
//   word_ready  loader accepts word_in this cycle
//   prgm_b      global programming strobe, low while configuring
//   cb_prgm_b / sb_prgm_b / CLB_prgm_b / io_prgm_b
//               per-chain shift enables (high = fabric samples this cycle)
//   bit_in_CB / bit_in_SB / bit_in_CLB / bit_in_IO
//               per-chain serial data
//   busy        configuration pass in progress
//   done        sticky, last pass completed; cleared by the next start
module config_stream_loader #(
    parameter int WORD_W   = 32,
    parameter int CB_BITS  = 768,
    parameter int SB_BITS  = 6912,
    parameter int CLB_BITS = 1184,
    parameter int IO_BITS  = 192
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [WORD_W-1:0] word_in,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              prgm_b,
    output logic              cb_prgm_b,
    output logic              sb_prgm_b,
    output logic              CLB_prgm_b,
    output logic              io_prgm_b,
    output logic              bit_in_CB,
    output logic              bit_in_SB,
    output logic              bit_in_CLB,
    output logic              bit_in_IO,
    output logic              busy,
    output logic              done
);

    localparam int MAX_AB   = (CB_BITS  > SB_BITS) ? CB_BITS  : SB_BITS;
    localparam int MAX_CD   = (CLB_BITS > IO_BITS) ? CLB_BITS : IO_BITS;
    localparam int MAX_BITS = (MAX_AB   > MAX_CD)  ? MAX_AB   : MAX_CD;
    localparam int CNT_W    = $clog2(MAX_BITS + 1);
    localparam int WCNT_W   = $clog2(WORD_W + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_CB,
        LOAD_SB,
        LOAD_CLB,
        LOAD_IO,
        DONE
    } state_t;

    state_t              state;
    state_t              next_load;
    logic [WORD_W-1:0]   shreg;      // bits of the current word not yet presented
    logic [WCNT_W-1:0]   count;      // number of valid bits left in shreg
    logic [CNT_W-1:0]    bit_cnt;    // bits presented in the current section
    logic [3:0]          en_q;       // {IO, CLB, SB, CB} shift enables
    logic [3:0]          bit_q;      // {IO, CLB, SB, CB} serial data

    logic                loading;
    logic [CNT_W-1:0]    sec_bits;
    logic [3:0]          chain_oh;
    logic                sec_end;
    logic                accept;
    logic                have_bit;

    always_comb begin
        loading   = 1'b0;
        sec_bits  = '0;
        chain_oh  = '0;
        next_load = IDLE;
        case (state)
            LOAD_CB: begin
                loading   = 1'b1;
                sec_bits  = CNT_W'(CB_BITS);
                chain_oh  = 4'b0001;
                next_load = LOAD_SB;
            end
            LOAD_SB: begin
                loading   = 1'b1;
                sec_bits  = CNT_W'(SB_BITS);
                chain_oh  = 4'b0010;
                next_load = LOAD_CLB;
            end
            LOAD_CLB: begin
                loading   = 1'b1;
                sec_bits  = CNT_W'(CLB_BITS);
                chain_oh  = 4'b0100;
                next_load = LOAD_IO;
            end
            LOAD_IO: begin
                loading   = 1'b1;
                sec_bits  = CNT_W'(IO_BITS);
                chain_oh  = 4'b1000;
                next_load = DONE;
            end
            default: ;
        endcase
    end

    // sec_end is true while the section's final bit is on the chain; the
    // following edge closes the section, so no new word may be taken then.
    assign sec_end    = loading && (bit_cnt == sec_bits);
    // count tracks bits still waiting in shreg (the bit on the output is
    // already out of it), so count==0 means the output holds the last bit of
    // the word and a new one can be taken without a bubble.
    assign word_ready = loading && !sec_end && (count == '0);
    assign accept     = word_ready && word_valid;
    assign have_bit   = loading && !sec_end && (count != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            shreg   <= '0;
            count   <= '0;
            bit_cnt <= '0;
            en_q    <= '0;
            bit_q   <= '0;
            prgm_b  <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= LOAD_CB;
                        prgm_b <= 1'b0;
                        busy   <= 1'b1;
                        done   <= 1'b0;
                    end
                end
                LOAD_CB, LOAD_SB, LOAD_CLB, LOAD_IO: begin
                    if (sec_end) begin
                        // Close the section: drop leftover word bits and
                        // park the finished chain at enable=0, data=0.
                        state   <= next_load;
                        shreg   <= '0;
                        count   <= '0;
                        bit_cnt <= '0;
                        en_q    <= '0;
                        bit_q   <= '0;
                        if (next_load == DONE) begin
                            prgm_b <= 1'b1;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                        end
                    end else if (accept) begin
                        shreg   <= word_in >> 1;
                        count   <= WCNT_W'(WORD_W - 1);
                        bit_cnt <= bit_cnt + CNT_W'(1);
                        en_q    <= chain_oh;
                        bit_q   <= chain_oh & {4{word_in[0]}};
                    end else if (have_bit) begin
                        shreg   <= shreg >> 1;
                        count   <= count - WCNT_W'(1);
                        bit_cnt <= bit_cnt + CNT_W'(1);
                        en_q    <= chain_oh;
                        bit_q   <= chain_oh & {4{shreg[0]}};
                    end else begin
                        // Starved: stop shifting, data line holds.
                        en_q <= '0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign cb_prgm_b  = en_q[0];
    assign sb_prgm_b  = en_q[1];
    assign CLB_prgm_b = en_q[2];
    assign io_prgm_b  = en_q[3];
    assign bit_in_CB  = bit_q[0];
    assign bit_in_SB  = bit_q[1];
    assign bit_in_CLB = bit_q[2];
    assign bit_in_IO  = bit_q[3];

endmodule

// File: doc/config_stream_loader.md
Name: config_stream_loader

Overview:
- Synthesizable configuration controller that sits directly upstream of the FPGA fabric's configuration chains.
- Accepts the device bitstream as 32-bit words over a valid/ready interface.
- Serializes the words, LSB first, into the CB, SB, CLB and IO chains, in that fixed order.
- Drives the global programming strobe (prgm_b) and the per-chain shift enables that the fabric consumes.

Parameters:
- WORD_W, 32, input word width.
- CB_BITS, 768, CB chain length (16 CBs x 48 bits).
- SB_BITS, 6912, SB chain length (9 SBs x 768 bits).
- CLB_BITS, 1184, CLB chain length (32 CLBs x 37 bits).
- IO_BITS, 192, IO chain length (12 IO blocks x 16 bits).

Ports:
- clk  in  1  configuration clock.
- reset  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; begins a configuration pass.
- word_in  in  WORD_W  bitstream word.
- word_valid  in  1  word_in is valid.
- word_ready  out  1  loader accepts word_in this cycle.
- prgm_b  out  1  global programming strobe; low while configuring, high otherwise.
- cb_prgm_b  out  1  CB chain shift enable, high = shift.
- sb_prgm_b  out  1  SB chain shift enable.
- CLB_prgm_b  out  1  CLB chain shift enable.
- io_prgm_b  out  1  IO chain shift enable.
- bit_in_CB  out  1  CB serial data.
- bit_in_SB  out  1  SB serial data.
- bit_in_CLB  out  1  CLB serial data.
- bit_in_IO  out  1  IO serial data.
- busy  out  1  configuration pass in progress.
- done  out  1  sticky; last pass completed; cleared by the next start.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE. prgm_b=1; all four *_prgm_b=0; all bit_in_*=0; word_ready=0; busy=0; done=0. Word buffer and all counters are cleared.
- FSM states: IDLE -> LOAD_CB -> LOAD_SB -> LOAD_CLB -> LOAD_IO -> DONE -> IDLE.
- IDLE: start=1 moves to LOAD_CB on the next edge. prgm_b=0, busy=1 and done=0 from that cycle on.
- start while busy is ignored.
- Word buffer: WORD_W-bit shift register plus a valid-bit count (0..WORD_W).
- word_ready=1 only in LOAD_* states, and only when count==0, or count==1 and a bit shifts this cycle. This allows back-to-back words with no bubble.
- A word is accepted on an edge with word_valid & word_ready.
- A word accepted at edge N drives its bit 0 on bit_in_<chain>, with <chain>_prgm_b=1, during cycle N+1.
- One bit per cycle thereafter. The fabric samples on posedge clk while <chain>_prgm_b=1.
- Stall: when the buffer is empty and no word is accepted, <chain>_prgm_b=0. bit_in holds its last value and the chain bit counter holds.
- Exactly one *_prgm_b may be high in any cycle. Chains not being loaded hold enable=0 and bit_in=0.
- Chain bit counter counts shifted bits. When it reaches <CHAIN>_BITS:
  - the enable drops on the following cycle;
  - the state advances;
  - any remaining bits in the current word are discarded (buffer cleared).
- Each section therefore starts on a word boundary. A section needs ceil(BITS/WORD_W) words: defaults 24, 216, 37, 6, for 283 words total.
- Bits within a section go out in ascending chain index: bit 0 of the first word is chain bit 0.
- Counters are sized to clog2(max BITS + 1). There is no wrap in normal operation; the counter clears on each state change.
- DONE (one cycle): prgm_b returns to 1, busy=0, done=1 (sticky). The state returns to IDLE.
- Extra words after DONE are not accepted (word_ready=0).
- Reset mid-pass: immediate return to reset values, with the partially loaded fabric left as-is. A new start restarts from CB bit 0.
- Minimum pass time with continuous word_valid: 1 + CB_BITS + SB_BITS + CLB_BITS + IO_BITS + 4 state-transition cycles. Defaults: 9061 cycles.

Test Plan:
1. Reset release, no start -> prgm_b=1, all enables 0, word_ready=0, busy=0 for 100 cycles.
2. Bench params CB_BITS=40, SB_BITS=32, CLB_BITS=8, IO_BITS=4; start, then words 0xA5A5A5A5, 0x000000FF, 0x12345678, 0x0000003C, 0x00000009 with valid held high ->
   - cb_prgm_b high 40 cycles: bits 1,0,1,0,0,1,0,1... then 0xFF low byte.
   - sb_prgm_b high 32 cycles: 0x12345678 LSB first.
   - CLB_prgm_b high 8 cycles: 0x3C (0,0,1,1,1,1,0,0).
   - io_prgm_b high 4 cycles: 1,0,0,1.
   - done=1; prgm_b=1.
3. Same as 2 with word_valid deasserted 5 cycles between each word -> enables drop during gaps, bit order identical, no bits lost or duplicated.
4. Defaults, random data, continuous valid -> exactly 283 words accepted, 9061 cycles from start to done, one-hot enables checked every cycle.
5. Reset asserted mid-SB load, released, start again -> outputs at reset values immediately; second pass begins at CB bit 0 and completes correctly.
6. start pulsed during LOAD_CLB, and word_valid held after done -> no restart, word_ready stays 0 after DONE, done stays 1 until next start.
